// File: rtl/fifo_stream_drain.sv
// Drain stage for sync_fifo: pops words into a 3-entry buffer and emits them as a valid/ready stream.
// Optional accepted-beat counter enabled by defining DRAIN_CNT_EN.
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  beat_count
);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_buf [3];

  logic                  w_pop;
  logic                  w_cap;
  logic [2:0]            w_occ_sum;
  logic [1:0]            w_occ_next;
  logic [1:0]            w_wr_idx;
  logic [DATA_WIDTH-1:0] w_buf_next [3];

  assign w_pop     = r_valid & m_ready;
  assign w_cap     = r_inflight & ~flush;
  assign w_occ_sum = {1'b0, r_occ} + {2'b00, r_inflight};

  // Reads are only issued while every outstanding word still has a slot reserved.
  assign fifo_read_en = ~fifo_empty & ~flush & ~reset & (w_occ_sum < 3'd3);

  assign w_occ_next = flush ? 2'd0 : (r_occ + {1'b0, w_cap} - {1'b0, w_pop});
  assign w_wr_idx   = r_occ - {1'b0, w_pop};

  // Head is always slot 0 so m_data comes straight off a flop; a pop shifts the rest down.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_buf_next[i] = r_buf[i];
    end
    if (w_pop) begin
      for (int i = 0; i < 2; i++) begin
        w_buf_next[i] = r_buf[i+1];
      end
    end
    if (w_cap) begin
      for (int i = 0; i < 3; i++) begin
        if (w_wr_idx == 2'(i)) begin
          w_buf_next[i] = fifo_dout;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_occ      <= w_occ_next;
      r_inflight <= fifo_read_en;
      r_valid    <= (w_occ_next != 2'd0);
      for (int i = 0; i < 3; i++) begin
        r_buf[i] <= w_buf_next[i];
      end
    end
  end

  assign m_data  = r_buf[0];
  assign m_valid = r_valid;
  assign idle    = (r_occ == 2'd0) & ~r_inflight;

`ifdef DRAIN_CNT_EN
  logic [CNT_WIDTH-1:0] r_beat_count;

  // Flush does not clear the counter: beats accepted before a flush were really delivered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_count <= '0;
    end else if (w_pop) begin
      r_beat_count <= r_beat_count + 1'b1;
    end
  end

  assign beat_count = r_beat_count;
`else
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Randomised self-checking bench for fifo_stream_drain against a FIFO model and an in-order scoreboard.
// Beat counter expectations follow DRAIN_CNT_EN.
module tb_fifo_stream_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_read_en;
  logic        flush = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        idle;
  logic [3:0]  beat_count;

  fifo_stream_drain #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_read_en(fifo_read_en), .flush(flush), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .idle(idle), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  // Behavioural sync_fifo: words stored by index, popped word presented for the following cycle.
  logic [31:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_read_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          hs_total = 0;
  int          exp_idx  = 0;
  logic        s_valid, s_idle, s_ren;
  logic [31:0] s_data;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  function automatic logic [3:0] exp_cnt();
`ifdef DRAIN_CNT_EN
    return 4'(hs_total);
`else
    return 4'd0;
`endif
  endfunction

  task automatic push(input logic [31:0] v);
    mem[wr_ptr % 256] = v;
    wr_ptr++;
  endtask

  // One cycle: sample at negedge, check invariants, then drive ready/flush for the next posedge.
  task automatic step(input bit rdy, input bit fl);
    @(negedge clk);
    s_valid = m_valid; s_data = m_data; s_idle = idle; s_ren = fifo_read_en;
    n_checks++;
    if (rd_ptr - exp_idx > 3 || rd_ptr - exp_idx < 0) begin
      n_errors++; $display("FAIL overflow_never: outstanding=%0d limit 0..3", rd_ptr - exp_idx);
    end
    if (prev_hold) begin
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== prev_data) begin
        n_errors++; $display("FAIL stable: valid=%b data=%h want valid=1 data=%h", s_valid, s_data, prev_data);
      end
    end
    n_checks++;
    if (beat_count !== exp_cnt()) begin
      n_errors++; $display("FAIL beat_count: got %0d want %0d", beat_count, exp_cnt());
    end
    m_ready = rdy;
    flush   = fl;
    if (s_valid && rdy) begin
      n_checks++;
      if (s_data !== mem[exp_idx % 256]) begin
        n_errors++; $display("FAIL order: beat %0d got %h want %h", exp_idx, s_data, mem[exp_idx % 256]);
      end
      $display("beat idx=%0d data=%h", exp_idx, s_data);
      exp_idx++;
      hs_total++;
    end
    prev_hold = s_valid && !rdy && !fl;
    prev_data = s_data;
    if (fl) exp_idx = rd_ptr;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (fifo_read_en !== 1'b0 || m_valid !== 1'b0 || idle !== 1'b1 || beat_count !== 4'd0 || m_data !== 32'd0) begin
      n_errors++;
      $display("FAIL %s: ren=%b valid=%b idle=%b cnt=%0d data=%h want 0 0 1 0 0",
               tag, fifo_read_en, m_valid, idle, beat_count, m_data);
    end
  endtask

  task automatic test_reset();
    #2;
    check_reset_outputs("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_idx = rd_ptr; hs_total = 0; prev_hold = 1'b0;
    step(1'b1, 1'b0);
    n_checks++;
    if (s_ren !== 1'b0 || s_valid !== 1'b0 || s_idle !== 1'b1) begin
      n_errors++; $display("FAIL empty_idle: ren=%b valid=%b idle=%b want 0 0 1", s_ren, s_valid, s_idle);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
    #1;
    n_checks++;
    if (fifo_read_en !== 1'b1) begin
      n_errors++; $display("FAIL first_read_en: got %b want 1", fifo_read_en);
    end
    step(1'b1, 1'b0);
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_errors++; $display("FAIL latency_n1: valid=%b want 0", s_valid);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if (s_valid !== 1'b1) begin
        n_errors++; $display("FAIL no_bubble: cycle %0d valid=%b want 1", i, s_valid);
      end
    end
    step(1'b1, 1'b0);
    n_checks++;
    if (s_valid !== 1'b0 || s_idle !== 1'b1 || exp_idx != wr_ptr) begin
      n_errors++; $display("FAIL b2b_end: valid=%b idle=%b left=%0d want 0 1 0", s_valid, s_idle, wr_ptr - exp_idx);
    end
  endtask

  task automatic test_backpressure();
    int start;
    step(1'b0, 1'b0);
    start = rd_ptr;
    for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    n_checks++;
    if (rd_ptr - start != 3 || s_ren !== 1'b0 || s_valid !== 1'b1 || s_data !== 32'hA0) begin
      n_errors++;
      $display("FAIL bp_hold: reads=%0d ren=%b valid=%b data=%h want 3 0 1 a0", rd_ptr - start, s_ren, s_valid, s_data);
    end
    for (int c = 0; c < 40 && exp_idx != wr_ptr; c++) step(1'b1, 1'b0);
    n_checks++;
    if (exp_idx != wr_ptr) begin
      n_errors++; $display("FAIL bp_drain: delivered=%0d want %0d", exp_idx - start, wr_ptr - start);
    end
    step(1'b1, 1'b0);
  endtask

  task automatic test_random();
    int pend = 16;
    for (int c = 0; c < 400 && (pend > 0 || exp_idx != wr_ptr); c++) begin
      if (pend > 0 && $urandom_range(0, 2) == 0) begin
        push($urandom);
        pend--;
      end
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    n_checks++;
    if (pend != 0 || exp_idx != wr_ptr) begin
      n_errors++; $display("FAIL random_drain: pending=%0d left=%0d want 0 0", pend, wr_ptr - exp_idx);
    end
    step(1'b1, 1'b0);
  endtask

  task automatic test_flush();
    int start;
    step(1'b0, 1'b0);
    start = rd_ptr;
    for (int i = 0; i < 6; i++) push(32'hF0 + 32'(i));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    n_checks++;
    if (rd_ptr - start != 3 || s_valid !== 1'b1) begin
      n_errors++; $display("FAIL flush_setup: reads=%0d valid=%b want 3 1", rd_ptr - start, s_valid);
    end
    step(1'b1, 1'b0);
    n_checks++;
    if (s_valid !== 1'b0 || s_idle !== 1'b1) begin
      n_errors++; $display("FAIL flush_after: valid=%b idle=%b want 0 1", s_valid, s_idle);
    end
    n_checks++;
    if (exp_idx != start + 3) begin
      n_errors++; $display("FAIL flush_resume: next word %0d want %0d", exp_idx - start, 3);
    end
    for (int c = 0; c < 30 && exp_idx != wr_ptr; c++) step(1'b1, 1'b0);
    n_checks++;
    if (exp_idx != wr_ptr) begin
      n_errors++; $display("FAIL flush_drain: left=%0d want 0", wr_ptr - exp_idx);
    end
    step(1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 10; i++) push($urandom);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_idx = rd_ptr; hs_total = 0; prev_hold = 1'b0;
    for (int c = 0; c < 40 && exp_idx != wr_ptr; c++) step(1'b1, 1'b0);
    n_checks++;
    if (exp_idx != wr_ptr) begin
      n_errors++; $display("FAIL reset_resume: left=%0d want 0", wr_ptr - exp_idx);
    end
    step(1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_flush();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
